// File: rtl/factorial_engine_if.sv
// GO/DONE handshake and result bus of the factorial engine.
// The engine sits on the slave side; the host drives the master side.
interface factorial_engine_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4
);
  logic               GO;
  logic [N_WIDTH-1:0] N;
  logic               BUSY;
  logic               DONE;
  logic               ERR;
  logic [WIDTH-1:0]   RESULT;

  modport master (output GO, output N, input BUSY, input DONE, input ERR, input RESULT);
  modport slave  (input GO, input N, output BUSY, output DONE, output ERR, output RESULT);
endinterface

// File: rtl/factorial_engine.sv
// Iterative factorial unit: RESULT = N! mod 2^WIDTH, with an overflow flag.
// The product is multiplied by a down-counter from N to 2, one step per clock.
module factorial_engine #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  factorial_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [N_WIDTH-1:0]   counter_reg, counter_next;
  logic [WIDTH-1:0]     product_reg, product_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 err_reg, err_next;
  logic                 ovf_reg, ovf_next;
  logic                 busy, done;

  logic [2*WIDTH-1:0]   product_ext;
  logic [2*WIDTH-1:0]   counter_ext;
  logic [2*WIDTH-1:0]   full_product;

  assign product_ext  = {{WIDTH{1'b0}}, product_reg};
  assign counter_ext  = {{(2*WIDTH-N_WIDTH){1'b0}}, counter_reg};
  assign full_product = product_ext * counter_ext;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      product_reg <= '0;
      result_reg  <= '0;
      err_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      product_reg <= product_next;
      result_reg  <= result_next;
      err_reg     <= err_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    product_next = product_reg;
    result_next  = result_reg;
    err_next     = err_reg;
    ovf_next     = ovf_reg;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.GO) begin
          counter_next = bus.N;
          product_next = WIDTH'(1);
          ovf_next     = 1'b0;
          err_next     = 1'b0;
          state_next   = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (counter_reg > N_WIDTH'(1)) begin
          // Overflow is sticky: later truncated steps cannot clear it.
          product_next = full_product[WIDTH-1:0];
          ovf_next     = ovf_reg | (|full_product[2*WIDTH-1:WIDTH]);
          counter_next = counter_reg - N_WIDTH'(1);
        end else begin
          result_next = product_reg;
          err_next    = ovf_reg;
          state_next  = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.ERR    = err_reg;
  assign bus.RESULT = result_reg;

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: a vector table on 32- and 16-bit
// instances plus hand-written sequences for GO retrigger, GO held and reset.
module tb_factorial_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  factorial_engine_if #(.WIDTH(32), .N_WIDTH(4)) if32 ();
  factorial_engine_if #(.WIDTH(16), .N_WIDTH(4)) if16 ();

  factorial_engine #(.WIDTH(32), .N_WIDTH(4)) u_dut32 (
    .CLK (clk),
    .RST (rst),
    .bus (if32)
  );

  factorial_engine #(.WIDTH(16), .N_WIDTH(4)) u_dut16 (
    .CLK (clk),
    .RST (rst),
    .bus (if16)
  );

  typedef struct {
    bit          w16;
    int          n;
    logic [31:0] res;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_go(input bit w16, input bit go, input int n);
    if (w16) begin
      if16.GO = go;
      if16.N  = 4'(n);
    end else begin
      if32.GO = go;
      if32.N  = 4'(n);
    end
  endtask

  // Pulses GO for one cycle and follows the operation to DONE, then watches
  // two extra cycles for stray DONE pulses. Cycle 1 is the cycle after acceptance.
  task automatic run_op(input bit w16, input int n, output logic [31:0] res,
                        output bit err, output int lat, output int busy_cnt,
                        output int done_cnt);
    bit d, b;
    res = '0; err = 1'b0; lat = -1; busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    set_go(w16, 1'b1, n);
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_go(w16, 1'b0, 0);
      d = w16 ? if16.DONE : if32.DONE;
      b = w16 ? if16.BUSY : if32.BUSY;
      if (b) busy_cnt++;
      if (d) begin
        done_cnt++;
        lat = cyc;
        res = w16 ? 32'(if16.RESULT) : if32.RESULT;
        err = w16 ? if16.ERR : if32.ERR;
        break;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d = w16 ? if16.DONE : if32.DONE;
      if (d) done_cnt++;
    end
  endtask

  initial begin
    logic [31:0] res;
    bit          err;
    int          lat, busy_cnt, done_cnt, exp_busy;
    int          first_done, second_done;

    vecs[0] = '{1'b0,  5, 32'd120,        1'b0,  6};
    vecs[1] = '{1'b0,  0, 32'd1,          1'b0,  2};
    vecs[2] = '{1'b0,  1, 32'd1,          1'b0,  2};
    vecs[3] = '{1'b0, 12, 32'd479001600,  1'b0, 13};
    vecs[4] = '{1'b0, 13, 32'd1932053504, 1'b1, 14};
    vecs[5] = '{1'b0,  3, 32'd6,          1'b0,  4};
    vecs[6] = '{1'b1,  8, 32'd40320,      1'b0,  9};
    vecs[7] = '{1'b1,  9, 32'd35200,      1'b1, 10};

    if32.GO = 1'b0; if32.N = '0;
    if16.GO = 1'b0; if16.N = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_result", if32.RESULT, 32'd0);
    check("reset_err",    32'(if32.ERR),  32'd0);
    check("reset_busy",   32'(if32.BUSY), 32'd0);
    check("reset_done",   32'(if32.DONE), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].w16, vecs[i].n, res, err, lat, busy_cnt, done_cnt);
      exp_busy = (vecs[i].n > 1) ? vecs[i].n : 1;
      $display("op w%0d N=%0d: result=%0d err=%0d done_cycle=%0d busy=%0d dones=%0d",
               vecs[i].w16 ? 16 : 32, vecs[i].n, res, err, lat, busy_cnt, done_cnt);
      check($sformatf("v%0d_result", i),  res,               vecs[i].res);
      check($sformatf("v%0d_err", i),     32'(err),          32'(vecs[i].err));
      check($sformatf("v%0d_latency", i), 32'(lat),          32'(vecs[i].lat));
      check($sformatf("v%0d_busy", i),    32'(busy_cnt),     32'(exp_busy));
      check($sformatf("v%0d_dones", i),   32'(done_cnt),     32'd1);
    end

    // N=7 with a second GO (N=2) pulsed during CALC: it must be ignored.
    @(negedge clk);
    set_go(1'b0, 1'b1, 7);
    @(posedge clk);
    done_cnt = 0; lat = -1; res = '0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_go(1'b0, 1'b0, 0);
      if (cyc == 2) set_go(1'b0, 1'b1, 2);
      if (cyc == 3) set_go(1'b0, 1'b0, 0);
      if (if32.DONE) begin
        done_cnt++;
        lat = cyc;
        res = if32.RESULT;
      end
    end
    $display("op retrigger N=7: result=%0d done_cycle=%0d dones=%0d", res, lat, done_cnt);
    check("retrig_result",  res,           32'd5040);
    check("retrig_latency", 32'(lat),      32'd8);
    check("retrig_dones",   32'(done_cnt), 32'd1);

    // GO held high with N=2: restart in the IDLE cycle after each FIN.
    @(negedge clk);
    set_go(1'b0, 1'b1, 2);
    @(posedge clk);
    done_cnt = 0; first_done = -1; second_done = -1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (if32.DONE) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
      end
    end
    set_go(1'b0, 1'b0, 0);
    $display("op held GO N=2: dones=%0d at cycles %0d,%0d result=%0d",
             done_cnt, first_done, second_done, if32.RESULT);
    check("hold_dones",  32'(done_cnt),    32'd2);
    check("hold_first",  32'(first_done),  32'd3);
    check("hold_second", 32'(second_done), 32'd7);
    check("hold_result", if32.RESULT,      32'd2);
    repeat (6) @(negedge clk);

    // N=10 abandoned by reset in cycle 4; then a fresh N=4.
    set_go(1'b0, 1'b1, 10);
    @(posedge clk);
    done_cnt = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_go(1'b0, 1'b0, 0);
      if (if32.DONE) done_cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("op reset N=10: busy=%0d done=%0d result=%0d err=%0d",
             if32.BUSY, if32.DONE, if32.RESULT, if32.ERR);
    check("rst_busy",   32'(if32.BUSY), 32'd0);
    check("rst_done",   32'(if32.DONE), 32'd0);
    check("rst_result", if32.RESULT,    32'd0);
    check("rst_err",    32'(if32.ERR),  32'd0);
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (if32.DONE) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);

    run_op(1'b0, 4, res, err, lat, busy_cnt, done_cnt);
    $display("op after reset N=4: result=%0d err=%0d done_cycle=%0d", res, err, lat);
    check("post_rst_result",  res,      32'd24);
    check("post_rst_err",     32'(err), 32'd0);
    check("post_rst_latency", 32'(lat), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
